// File: rtl/spec_fifo_arb.sv
// Round-robin write-side arbiter for a speculative FIFO.
// One producer owns the FIFO write port for a whole packet. The last beat
// commits it; an abort, or too long without progress, reverts it, so the
// FIFO reader only ever sees complete packets.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner, outputs quiet, next owner picked from rr_ptr upward
// BUSY  | owner_q streams beats into the FIFO until commit or revert
module spec_fifo_arb #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ-1:0]         req_abort,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       fifo_valid_in,
    output logic [WIDTH-1:0]           fifo_data_in,
    input  logic                       fifo_ready_in,
    output logic                       fifo_commit,
    output logic                       fifo_revert,
    output logic                       timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    int                 pick_scan;
    logic               busy;
    logic               accept;
    logic               abort_g;
    logic               stall_hit;
    logic               done;

    // Round-robin search: scan offsets high to low so the smallest offset
    // from rr_ptr that has a valid request is the one left standing.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_scan  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pick_scan = int'(rr_ptr_q) + i;
            if (pick_scan >= NUM_REQ) begin
                pick_scan = pick_scan - NUM_REQ;
            end
            if (req_valid[PTR_W'(pick_scan)]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(pick_scan);
            end
        end
    end

    // Data path and handshake outputs, purely combinational from the owner.
    // Abort wins over last so a packet is never committed and reverted at once.
    always_comb begin
        busy          = (state_q == S_BUSY);
        req_ready     = '0;
        fifo_valid_in = 1'b0;
        fifo_data_in  = '0;
        if (busy) begin
            req_ready[owner_q] = fifo_ready_in;
            fifo_valid_in      = req_valid[owner_q];
            fifo_data_in       = req_data[int'(owner_q) * WIDTH +: WIDTH];
        end
        accept      = busy & req_valid[owner_q] & fifo_ready_in;
        abort_g     = busy & req_abort[owner_q];
        stall_hit   = busy & (stall_cnt_q == CNT_W'(TIMEOUT - 1)) & ~accept;
        fifo_commit = accept & req_last[owner_q] & ~abort_g;
        fifo_revert = abort_g | stall_hit;
        timeout_err = stall_hit & ~abort_g;
        done        = fifo_commit | fifo_revert;
    end

    // Next-state: grant on request, release on commit/revert, track stalls.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d     = S_BUSY;
                    grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d     = pick_idx;
                    stall_cnt_d = '0;
                end
            end
            S_BUSY: begin
                if (done) begin
                    state_d     = S_IDLE;
                    grant_d     = '0;
                    stall_cnt_d = '0;
                    rr_ptr_d    = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end else if (accept) begin
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All sequencer registers; reset drops any packet in flight at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant = grant_q;

endmodule
